dl_bus_arbiter: RTL and testbench
=================================

# dl_bus_arbiter

Arbiter and sequencer for the internal DL databus. It shares DL among four drivers: data bridge (DV→DL), register-file readout, ALU result and external data latch. It grants the bus one-hot, inserts a precharge turnaround cycle between owners, and generates the `DataOut` enable for the data bridge. A watchdog bounds locked ownership so no requester holds DL indefinitely.

## Interface
- `TIMEOUT`, default 15: maximum consecutive granted cycles for one owner (legal range 1..255).
- `CLK2`  input  1  core clock; all state changes on rising edge.
- `RESET`  input  1  synchronous, active-high reset.
- `REQ`  input  4  bus requests: [0] data bridge, [1] register file, [2] ALU result, [3] external data latch.
- `LOCK`  input  4  requester i asks to keep DL beyond the current granted cycle; ignored unless `REQ[i]` is set.
- `GNT`  output  4  registered one-hot grant; `0000` when no owner.
- `DataOut`  output  1  registered; equals `GNT[0]`; drives the data bridge enable.
- `Owner`  output  2  index of the current or last owner.
- `BusIdle`  output  1  high when `GNT==0000`.
- `Timeout`  output  1  one-cycle pulse when ownership was force-released.

## Operation
- States:
  - IDLE: `GNT=0`.
  - GRANT: exactly one `GNT` bit set.
  - TURN: `GNT=0`; DL precharges, no driver enabled.
- Arbitration is evaluated in IDLE and TURN:
  - `REQ[3]` has absolute priority.
  - Otherwise round-robin over 0..2, starting from `(ptr+1) mod 3`.
  - On grant, `ptr` ← winner (for winners 0..2), `Owner` ← winner, hold counter ← 1. Next state is GRANT.
  - With no requests, next state is IDLE.
- GRANT, owner o:
  - Stay in GRANT if `REQ[o] & LOCK[o]` and hold counter < `TIMEOUT`; the counter increments.
  - Release to TURN if `REQ[o]` is low or `LOCK[o]` is low. `Timeout` stays 0.
  - Release to TURN with `Timeout=1` during the TURN cycle if `REQ[o] & LOCK[o]` and counter == `TIMEOUT`.
- No preemption: a higher-priority request never interrupts a GRANT.
- Hold counter width is `clog2(TIMEOUT+1)` and saturates at `TIMEOUT`; it never wraps.
- `DataOut`, `BusIdle` and `GNT` are derived from the same registered state, so they are always mutually consistent.
- A requester without `LOCK` gets exactly one granted cycle per arbitration.
- A force-released owner that is still requesting competes normally in TURN and may be regranted if it wins.
- Starvation of 0..2 by a permanently requesting `REQ[3]` is accepted. Its ownership is still bounded by `TIMEOUT`, with one TURN cycle between grants.

## Timing
- Reset values, visible in the cycle after `RESET` is sampled high:
  - outputs: `GNT=0000`, `DataOut=0`, `Owner=0`, `BusIdle=1`, `Timeout=0`;
  - internal: state IDLE, `ptr=2` (requester 0 first), counter 0.
- `RESET` mid-GRANT: the grant drops at the next edge. No TURN cycle and no `Timeout` pulse are generated.
- Request latency:
  - `REQ` sampled high at the edge ending cycle n (state IDLE) → `GNT` high in cycle n+1.
  - From TURN, the same one-cycle latency applies.
- Release:
  - `LOCK`/`REQ` low in granted cycle m → `GNT=0` in m+1 (TURN).
  - Earliest next grant is cycle m+2.
- Back-to-back owners are therefore separated by exactly one `GNT=0` cycle.
- Maximum continuous ownership is `TIMEOUT` cycles. `Timeout` is high only in the TURN cycle that follows a forced release.
- Simultaneous events:
  - `REQ[3]` rising in the same cycle the owner releases: 3 wins in the TURN evaluation.
  - Requests arriving while in GRANT are held pending until TURN.

## Test plan
- Reset: `RESET=1` for 2 cycles with `REQ=1111` → `GNT=0000`, `DataOut=0`, `BusIdle=1`, `Owner=0`, `Timeout=0`. After `RESET=0`, next cycle `GNT=1000`, `Owner=3`.
- Single bridge transfer: `REQ=0001` for one cycle, `LOCK=0` → cycle n+1 `GNT=0001`, `DataOut=1`; n+2 `GNT=0000` (TURN); n+3 `BusIdle=1`.
- Round-robin: `REQ=0111` held, `LOCK=0` → `GNT` sequence `0001, 0000, 0010, 0000, 0100, 0000, 0001`.
- Watchdog with `TIMEOUT=15`: `REQ[1]=LOCK[1]=1` held → `GNT=0010` for exactly 15 cycles, then one TURN cycle with `Timeout=1`, then `GNT=0010` again.
- Priority without preemption: owner 0 locked; `REQ[3]` and `REQ[1]` rise → `GNT=0001` is held until `LOCK[0]` drops, then TURN, then `GNT=1000`, then TURN, then `GNT=0010`.
- Reset mid-grant: assert `RESET` during the 5th locked cycle of owner 2 → next cycle `GNT=0000` and `Timeout=0`. After release with `REQ=0101`, `GNT=0001` first (`ptr` reset to 2).

Source files
------------

// File: rtl/dl_bus_arbiter_if.sv
// rtl/dl_bus_arbiter_if.sv - DL databus request/grant signal bundle
interface dl_bus_arbiter_if;
    logic [3:0] REQ;
    logic [3:0] LOCK;
    logic [3:0] GNT;
    logic       DataOut;
    logic [1:0] Owner;
    logic       BusIdle;
    logic       Timeout;

    modport master (
        output REQ, LOCK,
        input  GNT, DataOut, Owner, BusIdle, Timeout
    );

    modport slave (
        input  REQ, LOCK,
        output GNT, DataOut, Owner, BusIdle, Timeout
    );
endinterface

// File: rtl/dl_bus_arbiter.sv
// rtl/dl_bus_arbiter.sv - DL databus arbiter with turnaround cycle and ownership watchdog
module dl_bus_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic             CLK2,
    input  logic             RESET,
    dl_bus_arbiter_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_owner, w_owner_nxt;
    logic [1:0]    r_ptr,   w_ptr_nxt;
    logic [CW-1:0] r_cnt,   w_cnt_nxt;
    logic          r_timeout, w_timeout_nxt;
    logic [3:0]    r_gnt,   w_gnt_nxt;

    logic [1:0]    w_c0, w_c1, w_c2;
    logic [1:0]    w_winner;
    logic          w_any;
    logic          w_hold;

    // Round-robin search order over requesters 0..2, starting just after the last winner
    always_comb begin
        w_c0 = 2'd0;
        w_c1 = 2'd1;
        w_c2 = 2'd2;
        case (r_ptr)
            2'd0: begin w_c0 = 2'd1; w_c1 = 2'd2; w_c2 = 2'd0; end
            2'd1: begin w_c0 = 2'd2; w_c1 = 2'd0; w_c2 = 2'd1; end
            default: begin w_c0 = 2'd0; w_c1 = 2'd1; w_c2 = 2'd2; end
        endcase
    end

    // Pick a winner: external latch first, then the round-robin order
    always_comb begin
        w_any    = |bus.REQ;
        w_winner = 2'd0;
        if (bus.REQ[3])
            w_winner = 2'd3;
        else if (bus.REQ[w_c0])
            w_winner = w_c0;
        else if (bus.REQ[w_c1])
            w_winner = w_c1;
        else
            w_winner = w_c2;
        w_hold = bus.REQ[r_owner] & bus.LOCK[r_owner];
    end

    // Next-state logic: arbitrate in IDLE/TURN, hold or release in GRANT
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE, S_TURN: begin
                if (w_any) begin
                    w_state_nxt = S_GRANT;
                    w_owner_nxt = w_winner;
                    w_cnt_nxt   = ONE;
                    if (w_winner != 2'd3)
                        w_ptr_nxt = w_winner;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GRANT: begin
                if (w_hold && (r_cnt < TMAX)) begin
                    w_cnt_nxt = r_cnt + ONE;
                end else begin
                    // A locked owner reaching the limit is cut off and flagged
                    w_state_nxt   = S_TURN;
                    w_timeout_nxt = w_hold;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_gnt_nxt = (w_state_nxt == S_GRANT) ? (4'b0001 << w_owner_nxt) : 4'b0000;
    end

    // State register; reset drops any grant immediately without a TURN cycle
    always_ff @(posedge CLK2) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_owner   <= 2'd0;
            r_ptr     <= 2'd2;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
            r_gnt     <= 4'b0000;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
            r_gnt     <= w_gnt_nxt;
        end
    end

    assign bus.GNT     = r_gnt;
    assign bus.DataOut = r_gnt[0];
    assign bus.BusIdle = ~|r_gnt;
    assign bus.Owner   = r_owner;
    assign bus.Timeout = r_timeout;
endmodule

// File: tb/tb_dl_bus_arbiter.sv
// tb/tb_dl_bus_arbiter.sv - randomized and directed bench for dl_bus_arbiter
module tb_dl_bus_arbiter;
    localparam int TO = 15;

    logic CLK2;
    logic RESET;
    int   n_checks;
    int   n_errors;

    dl_bus_arbiter_if bus ();

    dl_bus_arbiter #(.TIMEOUT(TO)) dut (
        .CLK2  (CLK2),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK2 = 1'b0;
    always #5 CLK2 = ~CLK2;

    // Reference model: current owner (-1 when bus is free), last owner, rr pointer, hold length
    int m_gnt;
    int m_owner;
    int m_ptr;
    int m_hold;
    int m_tout;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic [3:0] req, input logic [3:0] lock, input logic rst);
        int win;
        if (rst) begin
            m_gnt = -1; m_owner = 0; m_ptr = 2; m_hold = 0; m_tout = 0;
        end else if (m_gnt >= 0) begin
            if (req[m_gnt] && lock[m_gnt] && m_hold < TO) begin
                m_hold++;
                m_tout = 0;
            end else begin
                m_tout = (req[m_gnt] && lock[m_gnt]) ? 1 : 0;
                m_gnt  = -1;
            end
        end else begin
            m_tout = 0;
            win = -1;
            if (req[3]) win = 3;
            else
                for (int k = 1; k <= 3; k++)
                    if (win < 0 && req[(m_ptr + k) % 3]) win = (m_ptr + k) % 3;
            if (win >= 0) begin
                m_gnt = win; m_owner = win; m_hold = 1;
                if (win < 3) m_ptr = win;
            end
        end
    endtask

    task automatic cyc(input logic [3:0] req, input logic [3:0] lock, input logic rst);
        logic [3:0] eg;
        bus.REQ  = req;
        bus.LOCK = lock;
        RESET    = rst;
        @(posedge CLK2);
        model_step(req, lock, rst);
        #1;
        eg = (m_gnt >= 0) ? (4'b0001 << m_gnt) : 4'b0000;
        chk("m_gnt",     32'(bus.GNT),     32'(eg));
        chk("m_dataout", 32'(bus.DataOut), 32'(eg[0]));
        chk("m_busidle", 32'(bus.BusIdle), 32'(eg == 4'b0000));
        chk("m_owner",   32'(bus.Owner),   32'(m_owner));
        chk("m_timeout", 32'(bus.Timeout), 32'(m_tout));
    endtask

    logic [3:0] rr_exp [7];
    int         n;

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_gnt = -1; m_owner = 0; m_ptr = 2; m_hold = 0; m_tout = 0;
        bus.REQ = 4'b0; bus.LOCK = 4'b0; RESET = 1'b1;

        // Reset with all requests pending
        cyc(4'b1111, 4'b0000, 1'b1);
        cyc(4'b1111, 4'b0000, 1'b1);
        chk("rst_gnt",     32'(bus.GNT), 32'h0);
        chk("rst_dataout", 32'(bus.DataOut), 32'h0);
        chk("rst_busidle", 32'(bus.BusIdle), 32'h1);
        chk("rst_owner",   32'(bus.Owner), 32'h0);
        chk("rst_timeout", 32'(bus.Timeout), 32'h0);
        cyc(4'b1111, 4'b0000, 1'b0);
        chk("rst_first_gnt",   32'(bus.GNT), 32'h8);
        chk("rst_first_owner", 32'(bus.Owner), 32'h3);
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);

        // Single bridge transfer
        cyc(4'b0001, 4'b0000, 1'b0);
        chk("br_gnt",     32'(bus.GNT), 32'h1);
        chk("br_dataout", 32'(bus.DataOut), 32'h1);
        cyc(4'b0000, 4'b0000, 1'b0);
        chk("br_turn", 32'(bus.GNT), 32'h0);
        cyc(4'b0000, 4'b0000, 1'b0);
        chk("br_idle", 32'(bus.BusIdle), 32'h1);

        // Round-robin from a fresh pointer
        cyc(4'b0000, 4'b0000, 1'b1);
        rr_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b0001};
        for (int i = 0; i < 7; i++) begin
            cyc(4'b0111, 4'b0000, 1'b0);
            chk("rr_seq", 32'(bus.GNT), 32'(rr_exp[i]));
        end
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);

        // Watchdog on a locked register-file owner
        cyc(4'b0010, 4'b0010, 1'b0);
        n = 0;
        while (bus.GNT == 4'b0010 && n < 40) begin
            n++;
            cyc(4'b0010, 4'b0010, 1'b0);
        end
        chk("wd_len",  32'(n), 32'(TO));
        chk("wd_turn", 32'(bus.GNT), 32'h0);
        chk("wd_tout", 32'(bus.Timeout), 32'h1);
        cyc(4'b0010, 4'b0010, 1'b0);
        chk("wd_regrant", 32'(bus.GNT), 32'h2);
        chk("wd_tout_clr", 32'(bus.Timeout), 32'h0);
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);

        // Priority without preemption
        cyc(4'b0001, 4'b0001, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(4'b1011, 4'b0001, 1'b0);
            chk("np_hold", 32'(bus.GNT), 32'h1);
        end
        cyc(4'b1011, 4'b0000, 1'b0);
        chk("np_turn1", 32'(bus.GNT), 32'h0);
        cyc(4'b1010, 4'b0000, 1'b0);
        chk("np_ext", 32'(bus.GNT), 32'h8);
        cyc(4'b0010, 4'b0000, 1'b0);
        chk("np_turn2", 32'(bus.GNT), 32'h0);
        cyc(4'b0010, 4'b0000, 1'b0);
        chk("np_rf", 32'(bus.GNT), 32'h2);
        cyc(4'b0000, 4'b0000, 1'b0);

        // Reset during the 5th locked cycle of owner 2
        for (int i = 0; i < 5; i++) cyc(4'b0100, 4'b0100, 1'b0);
        chk("rm_locked", 32'(bus.GNT), 32'h4);
        cyc(4'b0100, 4'b0100, 1'b1);
        chk("rm_gnt",  32'(bus.GNT), 32'h0);
        chk("rm_tout", 32'(bus.Timeout), 32'h0);
        cyc(4'b0101, 4'b0000, 1'b0);
        chk("rm_ptr", 32'(bus.GNT), 32'h1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] rq, lk;
            logic       rs;
            rq = ($urandom_range(0, 3) == 0) ? 4'($urandom) & 4'b0111 : 4'($urandom);
            lk = ($urandom_range(0, 2) == 0) ? 4'b1111 : 4'($urandom);
            rs = ($urandom_range(0, 199) == 0);
            cyc(rq, lk, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
